branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter BHT_DEPTH, default 64, number of 2-bit counters; power of 2, range 4..1024.
REQ-002 Parameter INIT_CTR, default 2'b01 (weakly not-taken), value written to every counter on clear.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pred_pc  input  32  fetch PC to predict.
REQ-006 pred_taken  output  1  prediction for pred_pc, combinational.
REQ-007 ready  output  1  high when the table is initialised and usable.
REQ-008 res_valid  input  1  a branch is being resolved this cycle.
REQ-009 res_pc  input  32  PC of the resolving branch.
REQ-010 branch_op  input  3  condition class.
REQ-011 branch_instruction  input  5  instruction[20:16], selects bgez or bltz.
REQ-012 judge_data  input  32  rs operand.
REQ-013 cmp_data  input  32  rt operand, used by beq and bne.
REQ-014 branch_enable  output  1  resolved outcome, combinational.
REQ-015 mispredict  output  1  registered; high for one cycle after a wrong-predicted resolve.

Function
REQ-016 Conditions: bgez/bltz (op 000) use rt field 00001 for bgez (rs>=0), 00000 for bltz (rs<0) and any other value for bltz; blez 001 (rs<=0); bgtz 010 (rs>0); jalr 011 (always 1); beq 100 (rs==rt); bne 101 (rs!=rt); 110 and 111 give 0.
REQ-017 All comparisons are signed two's complement on 32 bits; zero is tested on all 32 bits.
REQ-018 Table index is pc[IDX_W+1:2], IDX_W=log2(BHT_DEPTH); bits [1:0] are ignored.
REQ-019 pred_taken = counter[1] of the pred_pc entry when ready=1, else 0.
REQ-020 FSM states: CLEAR, RUN; after rst the FSM is in CLEAR, writes INIT_CTR to one entry per cycle from index 0 upward, and enters RUN after writing index BHT_DEPTH-1; ready=1 only in RUN.
REQ-021 In RUN, a res_valid cycle updates the res_pc entry at the next edge: taken increments, saturating at 11; not-taken decrements, saturating at 00.
REQ-022 res_valid in CLEAR is ignored: no update, mispredict stays 0.
REQ-023 mispredict(t+1) = res_valid & ready & (branch_enable != stored counter[1] of res_pc entry before update).
REQ-024 Prediction and update on the same index in one cycle: pred_taken uses the pre-update value.
REQ-025 Back-to-back resolves to the same index on consecutive cycles each see the previous cycle's update.

Reset
REQ-026 rst=1 at any edge forces state CLEAR, clear index 0, mispredict 0, ready 0, and clears the stat counters; this includes mid-CLEAR and mid-RUN.
REQ-027 Counter contents are not defined until CLEAR completes; a mid-CLEAR reset restarts the sweep from 0.

Configuration
REQ-028 Macro BRANCH_STATS_EN: when defined, 32-bit outputs stat_branches (res_valid&ready count) and stat_mispredicts (mispredict count) are present, both wrapping modulo 2^32.
REQ-029 When BRANCH_STATS_EN is not defined, neither port nor counter exists; all other behaviour is identical.

Structure
REQ-030 A shared package holds the branch_op codes, the rt-field codes 00001 and 00000, the counter states 00..11 and the FSM state encodings.
REQ-031 Sub-module branch_cond_eval holds the combinational condition logic of REQ-016/017; the top level holds the table, FSM and stats.

Verification
REQ-032 Reset, then count cycles until ready -> ready rises after exactly 64 cycles (default); pred_taken=0 for every pc before that point.
REQ-033 op=100, rs=rt=5, res_pc=0x40, 3 resolves -> counter goes 01,10,11,11; mispredict pulses on the 1st resolve only; pred_taken(0x40)=1.
REQ-034 op=000, rt-field 00001, rs=0 -> branch_enable=1; rt-field 00000, rs=0x80000000 -> 1; op=010, rs=0 -> 0; op=111 -> 0.
REQ-035 Predict and resolve pc 0x100 in the same cycle with counter 01 and taken outcome -> pred_taken=0 that cycle and 1 on the next cycle.
REQ-036 rst asserted in RUN after 10 resolves -> ready=0, then a full 64-cycle sweep; with BRANCH_STATS_EN, both stats read 0.
REQ-037 pcs 0x0 and 0x100 with BHT_DEPTH=64 -> both share index 0; aliasing confirmed by the shared counter update.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit: condition codes, rt-field
// selectors, 2-bit counter states and FSM encodings.
package branch_predict_unit_pkg;

    localparam logic [2:0] OP_BGEZ_BLTZ = 3'b000;
    localparam logic [2:0] OP_BLEZ      = 3'b001;
    localparam logic [2:0] OP_BGTZ      = 3'b010;
    localparam logic [2:0] OP_JALR      = 3'b011;
    localparam logic [2:0] OP_BEQ       = 3'b100;
    localparam logic [2:0] OP_BNE       = 3'b101;

    localparam logic [4:0] RT_BGEZ = 5'b00001;
    localparam logic [4:0] RT_BLTZ = 5'b00000;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_state_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bpu_state_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_STRONG_T)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != CTR_STRONG_NT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// Combinational branch condition evaluation; module branch_cond_eval.
// All tests treat operands as signed 32-bit two's complement.
module branch_cond_eval
    import branch_predict_unit_pkg::*;
(
    input  logic [2:0]  branch_op,
    input  logic [4:0]  branch_instruction,
    input  logic [31:0] judge_data,
    input  logic [31:0] cmp_data,
    output logic        branch_enable
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = judge_data[31];
    assign rs_zero = (judge_data == 32'd0);

    // Unknown rt-field values under op 000 fall back to bltz behaviour.
    always_comb begin
        branch_enable = 1'b0;
        case (branch_op)
            OP_BGEZ_BLTZ: begin
                case (branch_instruction)
                    RT_BGEZ: branch_enable = ~rs_neg;
                    RT_BLTZ: branch_enable = rs_neg;
                    default: branch_enable = rs_neg;
                endcase
            end
            OP_BLEZ: branch_enable = rs_neg | rs_zero;
            OP_BGTZ: branch_enable = ~rs_neg & ~rs_zero;
            OP_JALR: branch_enable = 1'b1;
            OP_BEQ:  branch_enable = (judge_data == cmp_data);
            OP_BNE:  branch_enable = (judge_data != cmp_data);
            default: branch_enable = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit counter table swept to INIT_CTR after reset.
// Optional BRANCH_STATS_EN adds resolve and mispredict counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] INIT_CTR  = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic        ready,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic [2:0]  branch_op,
    input  logic [4:0]  branch_instruction,
    input  logic [31:0] judge_data,
    input  logic [31:0] cmp_data,
    output logic        branch_enable,
    output logic        mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    bpu_state_e       state;
    logic [IDX_W-1:0] clear_idx;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       pred_ctr;
    logic [1:0]       res_ctr;
    logic             unused_pc_bits;

    branch_cond_eval u_cond (
        .branch_op          (branch_op),
        .branch_instruction (branch_instruction),
        .judge_data         (judge_data),
        .cmp_data           (cmp_data),
        .branch_enable      (branch_enable)
    );

    assign pred_idx       = pred_pc[IDX_W+1:2];
    assign res_idx        = res_pc[IDX_W+1:2];
    assign pred_ctr       = bht[pred_idx];
    assign res_ctr        = bht[res_idx];
    assign ready          = (state == ST_RUN);
    assign pred_taken     = ready & pred_ctr[1];
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                              res_pc[31:IDX_W+2], res_pc[1:0]};

    // Table contents are deliberately not reset; the CLEAR sweep initialises them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clear_idx  <= '0;
            mispredict <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    bht[clear_idx] <= INIT_CTR;
                    clear_idx      <= clear_idx + 1'b1;
                    mispredict     <= 1'b0;
                    if (clear_idx == IDX_W'(BHT_DEPTH - 1))
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    mispredict <= res_valid & (branch_enable != res_ctr[1]);
                    if (res_valid)
                        bht[res_idx] <= ctr_next(res_ctr, branch_enable);
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (res_valid && ready)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
